// File: rtl/uart_rxfifo_if.sv
// rtl/uart_rxfifo_if.sv - UART receive FIFO bus: byte strobe in, register access, interrupt out
interface uart_rxfifo_if;
  logic        rxnew;
  logic [7:0]  rxdata;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        irq;

  modport master (
    output rxnew, rxdata, a, d, we, rd,
    input  spo, irq
  );

  modport slave (
    input  rxnew, rxdata, a, d, we, rd,
    output spo, irq
  );
endinterface

// File: rtl/uart_rxfifo.sv
// rtl/uart_rxfifo.sv - UART receive byte FIFO with registers and irq; RXFIFO_TIMEOUT_EN adds idle timeout
module uart_rxfifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic           clk,
  input logic           rstn,
  uart_rxfifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, thresh, thresh_eff;
  logic                  overrun, ien, irq_q, timeout;
  logic                  full, empty, pop, push, flush, ctrl_wr, thresh_wr;
  logic [31:0]           spo;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pop       = bus.rd && (bus.a == 3'd0) && !empty;
  // a full FIFO still takes the byte when the same cycle frees a slot
  assign push      = bus.rxnew && (!full || pop);
  assign ctrl_wr   = bus.we && (bus.a == 3'd2);
  assign thresh_wr = bus.we && (bus.a == 3'd3);
  assign flush     = ctrl_wr && bus.d[0];
  assign thresh_eff = (thresh == '0) ? {{DEPTH_LOG2{1'b0}}, 1'b1} : thresh;

  // pointers and occupancy; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // byte storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= bus.rxdata;
  end

  // control state: sticky overrun, interrupt enable, threshold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
      ien     <= 1'b0;
      thresh  <= {{DEPTH_LOG2{1'b0}}, 1'b1};
    end else begin
      if (ctrl_wr && bus.d[2])                           overrun <= 1'b0;
      else if (bus.rxnew && full && !pop && !flush)      overrun <= 1'b1;
      if (ctrl_wr)   ien    <= bus.d[1];
      if (thresh_wr) thresh <= bus.d[DEPTH_LOG2:0];
    end
  end

`ifdef RXFIFO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // idle counter runs only while bytes wait unread; any activity restarts it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (flush || push || pop) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // interrupt is registered from current state, one cycle behind it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq_q <= 1'b0;
    else       irq_q <= ien & ((count >= thresh_eff) | overrun | timeout);
  end

  // combinational register read mux
  always_comb begin
    spo = 32'd0;
    case (bus.a)
      3'd0: if (!empty) spo = {24'd0, mem[rd_ptr]};
      3'd1: spo = {16'd0, 8'(count), 4'd0, timeout, overrun, full, empty};
      3'd2: spo = {31'd0, ien};
      3'd3: spo = 32'(thresh);
      default: spo = 32'd0;
    endcase
  end

  assign bus.spo = spo;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_uart_rxfifo.sv
// tb/tb_uart_rxfifo.sv - scoreboard bench for uart_rxfifo
module tb_uart_rxfifo;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [31:0] val;

  always #5 clk = ~clk;

  uart_rxfifo_if bus ();

  uart_rxfifo #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rxnew = 1'b1;
    bus.rxdata = b;
    if (exp_q.size() < 16) exp_q.push_back(b);
    tick();
    bus.rxnew = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] addr, input logic [31:0] data);
    bus.a = addr;
    bus.d = data;
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] addr, output logic [31:0] v);
    bus.a = addr;
    #1;
    v = bus.spo;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] e;
    e = (exp_q.size() == 0) ? 32'd0 : {24'd0, exp_q.pop_front()};
    rd_reg(3'd0, val);
    check_eq(tag, val, e);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxnew = 0; bus.rxdata = 0; bus.a = 0; bus.d = 0; bus.we = 0; bus.rd = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_irq", {31'd0, bus.irq}, 32'd0);
    rd_reg(3'd0, val); check_eq("rst_data", val, 32'd0);
    rd_reg(3'd1, val); check_eq("rst_status", val, 32'h1);
    rd_reg(3'd2, val); check_eq("rst_ctrl", val, 32'd0);
    rd_reg(3'd3, val); check_eq("rst_thresh", val, 32'd1);
    rstn = 1'b1;
    tick();

    // three bytes in, three out
    push(8'h41); push(8'h42); push(8'h43);
    rd_reg(3'd1, val); check_eq("st3", val, 32'h300);
    for (int i = 0; i < 3; i++) rd_data("data3");
    rd_reg(3'd1, val); check_eq("st_empty", val, 32'h1);

    // unmapped register reads zero and ignores writes
    wr_reg(3'd5, 32'hFFFF_FFFF);
    rd_reg(3'd5, val); check_eq("unmapped", val, 32'd0);
    rd_reg(3'd1, val); check_eq("unmapped_st", val, 32'h1);

    // overflow: 17th byte dropped, overrun sticky until cleared
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    rd_reg(3'd1, val); check_eq("st_ovr", val, 32'h1006);
    wr_reg(3'd2, 32'h4);
    rd_reg(3'd1, val); check_eq("st_ovr_clr", val, 32'h1002);

    // full with simultaneous push and pop
    rd_reg(3'd0, val);
    check_eq("full_head", val, {24'd0, exp_q.pop_front()});
    exp_q.push_back(8'hAA);
    bus.rxnew = 1'b1; bus.rxdata = 8'hAA; bus.rd = 1'b1;
    tick();
    bus.rxnew = 1'b0; bus.rd = 1'b0;
    rd_reg(3'd1, val); check_eq("st_full_pp", val, 32'h1002);
    while (exp_q.size() > 0) rd_data("drain16");
    rd_reg(3'd1, val); check_eq("st_drained", val, 32'h1);

    // threshold interrupt
    wr_reg(3'd3, 32'd4);
    wr_reg(3'd2, 32'h2);
    push(8'h01); push(8'h02); push(8'h03);
    tick();
    check_eq("irq_3", {31'd0, bus.irq}, 32'd0);
    push(8'h04);
    check_eq("irq_lat", {31'd0, bus.irq}, 32'd0);
    tick();
    check_eq("irq_4", {31'd0, bus.irq}, 32'd1);
    rd_data("thr_pop");
    check_eq("irq_pop_lat", {31'd0, bus.irq}, 32'd1);
    tick();
    check_eq("irq_pop", {31'd0, bus.irq}, 32'd0);
    while (exp_q.size() > 0) rd_data("thr_drain");

    // idle timeout
    wr_reg(3'd3, 32'd8);
    push(8'h77);
    repeat (15) tick();
    rd_reg(3'd1, val); check_eq("to_early", val, 32'h100);
    tick();
`ifdef RXFIFO_TIMEOUT_EN
    rd_reg(3'd1, val); check_eq("to_flag", val, 32'h108);
    tick();
    check_eq("to_irq", {31'd0, bus.irq}, 32'd1);
`else
    rd_reg(3'd1, val); check_eq("to_flag", val, 32'h100);
    tick();
    check_eq("to_irq", {31'd0, bus.irq}, 32'd0);
`endif
    rd_data("to_pop");
    rd_reg(3'd1, val); check_eq("to_clr", val, 32'h1);
    tick();
    check_eq("to_irq_clr", {31'd0, bus.irq}, 32'd0);

    // flush beats a simultaneous push
    push(8'h11); push(8'h22);
    bus.rxnew = 1'b1; bus.rxdata = 8'h33;
    bus.a = 3'd2; bus.d = 32'h3; bus.we = 1'b1;
    tick();
    bus.rxnew = 1'b0; bus.we = 1'b0;
    exp_q.delete();
    rd_reg(3'd1, val); check_eq("st_flush", val, 32'h1);
    rd_reg(3'd0, val); check_eq("data_flush", val, 32'd0);

    // threshold 0 behaves as 1
    wr_reg(3'd3, 32'd0);
    push(8'h66);
    tick();
    check_eq("irq_thr0", {31'd0, bus.irq}, 32'd1);

    // reset mid-stream
    push(8'h67);
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check_eq("rst_mid_irq", {31'd0, bus.irq}, 32'd0);
    rd_reg(3'd1, val); check_eq("rst_mid_st", val, 32'h1);
    rd_reg(3'd3, val); check_eq("rst_mid_thr", val, 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    push(8'h55);
    rd_reg(3'd1, val); check_eq("post_rst_st", val, 32'h100);
    rd_data("post_rst_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rxfifo.md
UART_RXFIFO -- requirements
Module: uart_rxfifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, idle-timeout length in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rxnew  input  1  one-cycle strobe from UART receiver: rxdata valid.
REQ-006 SHALL have port rxdata  input  8  received byte.
REQ-007 SHALL have port a  input  3  word register select from mmapper.
REQ-008 SHALL have port d  input  32  write data.
REQ-009 SHALL have port we  input  1  write strobe, one cycle.
REQ-010 SHALL have port rd  input  1  read strobe, one cycle.
REQ-011 SHALL have port spo  output  32  read data, combinational from a and current state.
REQ-012 SHALL have port irq  output  1  level interrupt to interrupt_unit.

Function
REQ-013 SHALL implement circular byte FIFO: wr_ptr, rd_ptr, count, each DEPTH_LOG2+1 bits wide for count; pointers wrap modulo depth.
REQ-014 SHALL map registers: a=0 DATA, a=1 STATUS, a=2 CTRL, a=3 THRESH; a=4..7 read 0, writes ignored.
REQ-015 DATA read: spo = {24'b0, head byte}; if empty spo = 0.
REQ-016 Pop SHALL occur on the cycle rd=1 and a=0 and count!=0; next cycle head advances; no pop when empty.
REQ-017 Push SHALL occur on the cycle rxnew=1 and count<depth; byte visible on spo next cycle (latency 1).
REQ-018 rxnew while full and no same-cycle pop SHALL drop the byte and set sticky overrun.
REQ-019 rxnew while full with same-cycle pop SHALL accept both; count unchanged; no overrun.
REQ-020 Simultaneous push and pop while empty SHALL push only; pop ignored.
REQ-021 Simultaneous push and pop while non-empty SHALL leave count unchanged.
REQ-022 STATUS read: spo = {16'b0, count[7:0] zero-extended, 4'b0, timeout, overrun, full, empty}.
REQ-023 CTRL write: bit0 flush (ptrs, count := 0), bit1 ien (stored), bit2 clear overrun; CTRL read returns {31'b0, ien}.
REQ-024 Flush SHALL take priority over same-cycle push and pop; that pushed byte is discarded, overrun unchanged.
REQ-025 THRESH write stores d[DEPTH_LOG2:0]; read returns it zero-extended; value 0 treated as 1.
REQ-026 irq SHALL equal ien & ((count >= thresh) | overrun | timeout), registered, 1-cycle latency.

Reset
REQ-027 On rstn=0, asynchronously: ptrs, count = 0; overrun = 0; timeout = 0; ien = 0; thresh = 1; idle counter = 0; irq = 0.
REQ-028 Reset mid-operation SHALL discard all FIFO contents; first push after rstn release is stored at index 0.
REQ-029 spo after reset: DATA 0, STATUS 0x00000001.

Configuration
REQ-030 Macro RXFIFO_TIMEOUT_EN SHALL compile in idle-timeout logic.
REQ-031 With RXFIFO_TIMEOUT_EN: idle counter increments each cycle count!=0 and no push/pop, resets on push, pop, or flush; reaching TIMEOUT_CYCLES sets timeout flag, cleared by push, pop, or flush.
REQ-032 Without RXFIFO_TIMEOUT_EN: no idle counter; timeout bit reads 0; irq excludes timeout term.

Verification
REQ-033 Reset, push 0x41,0x42,0x43 -> STATUS 0x00000300; three DATA reads return 0x41,0x42,0x43; then STATUS 0x00000001.
REQ-034 DEPTH_LOG2=4: push 17 bytes -> count 16, full=1, overrun=1; CTRL write 0x4 -> overrun=0; 17th byte absent.
REQ-035 Full FIFO, rxnew and DATA rd same cycle -> count stays 16, overrun stays 0, new byte read last.
REQ-036 THRESH=4, ien=1: 3 pushes -> irq 0; 4th push -> irq 1 one cycle later; one pop -> irq 0.
REQ-037 RXFIFO_TIMEOUT_EN, TIMEOUT_CYCLES=16, THRESH=8, ien=1: push 1 byte, idle 16 cycles -> timeout=1, irq=1; pop -> both 0.
REQ-038 Flush with simultaneous rxnew -> STATUS 0x00000001; rstn low mid-stream -> irq 0 immediately, STATUS 0x00000001.
